// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: issues regfile operands to a combinational ALU and writes results back; SEQ_DIV_ZERO_TRAP_EN adds a divide-by-zero trap
module alu_issue_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [8:0] instr,
  input  logic       ld_valid,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic [2:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic       done,
  output logic [7:0] wb_data,
  output logic       carry_flag,
`ifdef SEQ_DIV_ZERO_TRAP_EN
  output logic       div_err,
`endif
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t     state_q, state_d;
  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0] rd_q, rd_d;
  logic       cy_q, cy_d, carry_q, carry_d, div_err_q, div_err_d, trap;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign wb_data    = res_q;
  assign carry_flag = carry_q;
  assign rd_data    = regs_q[rd_addr];
`ifdef SEQ_DIV_ZERO_TRAP_EN
  assign div_err    = div_err_q;
  assign trap       = op_q == 3'b110 && b_q == 8'h00;
`else
  assign trap       = 1'b0;
`endif
  // next-state, operand latching, result sampling and regfile write (writeback overrides a same-register load)
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    res_d       = res_q;
    cy_d        = cy_q;
    carry_d     = carry_q;
    div_err_d   = div_err_q;
    regs_d      = regs_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = instr[8:6];
          rd_d    = instr[5:4];
          a_d     = regs_q[instr[3:2]];
          b_d     = regs_q[instr[1:0]];
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        cy_d    = alu_carry;
        state_d = WB;
      end
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ld_valid) regs_d[ld_addr] = ld_data;
    if (done && !trap) begin
      regs_d[rd_q] = res_q;
      carry_d      = cy_q;
    end
    div_err_d = div_err_q | (done & trap);
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      cy_q      <= 1'b0;
      carry_q   <= 1'b0;
      div_err_q <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      cy_q      <= cy_d;
      carry_q   <= carry_d;
      div_err_q <= div_err_d;
      regs_q    <= regs_d;
    end
  end
endmodule
